// File: rtl/ext_pkg.sv
// ext_pkg: op codes shared by the extension unit and its users.
`default_nettype none

package ext_pkg;

  localparam int EXT_OP_W = 3;

  typedef logic [EXT_OP_W-1:0] ext_op_t;

  localparam ext_op_t EXT_ZERO = 3'd0;
  localparam ext_op_t EXT_SIGN = 3'd1;
  localparam ext_op_t EXT_LUI  = 3'd2;
  localparam ext_op_t EXT_BOFF = 3'd3;
  localparam ext_op_t EXT_LB   = 3'd4;
  localparam ext_op_t EXT_LBU  = 3'd5;
  localparam ext_op_t EXT_LH   = 3'd6;
  localparam ext_op_t EXT_LHU  = 3'd7;

endpackage

`default_nettype wire

// File: rtl/ext_core.sv
// ext_core: combinational immediate / load-data extension.
// Load ops (LB/LBU/LH/LHU) exist only when EXT_LOAD_EN is defined; otherwise they act as ZERO.
`default_nettype none

module ext_core
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [EXT_OP_W-1:0] i_op,
  input  logic [IN_W-1:0]     i_imm,
  input  logic [OUT_W-1:0]    i_data,
  input  logic [1:0]          i_boff,
  output logic [OUT_W-1:0]    o_result,
  output logic                o_err
);

`ifdef EXT_LOAD_EN
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_data[{i_boff, 3'b000} +: 8];
  assign w_half = i_data[{i_boff[1], 4'b0000} +: 16];
`else
  logic w_unused;
  assign w_unused = ^{i_data, i_boff};
`endif

  always_comb begin
    o_result = {{(OUT_W-IN_W){1'b0}}, i_imm};
    o_err    = 1'b0;
    case (i_op)
      EXT_SIGN: o_result = {{(OUT_W-IN_W){i_imm[IN_W-1]}}, i_imm};
      EXT_LUI:  o_result = {i_imm, {(OUT_W-IN_W){1'b0}}};
      EXT_BOFF: o_result = {{(OUT_W-IN_W-2){i_imm[IN_W-1]}}, i_imm, 2'b00};
`ifdef EXT_LOAD_EN
      EXT_LB:   o_result = {{(OUT_W-8){w_byte[7]}}, w_byte};
      EXT_LBU:  o_result = {{(OUT_W-8){1'b0}}, w_byte};
      EXT_LH, EXT_LHU: begin
        // Halfword loads from an odd byte address are unaligned: flag and zero
        if (i_boff[0]) begin
          o_result = '0;
          o_err    = 1'b1;
        end else if (i_op == EXT_LH) begin
          o_result = {{(OUT_W-16){w_half[15]}}, w_half};
        end else begin
          o_result = {{(OUT_W-16){1'b0}}, w_half};
        end
      end
`endif
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ext_pipe.sv
// ext_pipe: registered extension stage with valid/ready, 2-entry skid buffer and flush.
// Optional load extension enabled by defining EXT_LOAD_EN.
`default_nettype none

module ext_pipe
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [EXT_OP_W-1:0] in_op,
  input  logic [IN_W-1:0]     in_imm,
  input  logic [OUT_W-1:0]    in_data,
  input  logic [1:0]          in_boff,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_data,
  output logic                out_err
);

  logic [OUT_W-1:0] w_core_data;
  logic             w_core_err;
  logic             w_accept;
  logic             w_drain;

  logic             r_main_valid;
  logic [OUT_W-1:0] r_main_data;
  logic             r_main_err;
  logic             r_skid_valid;
  logic [OUT_W-1:0] r_skid_data;
  logic             r_skid_err;

  ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .i_op     (in_op),
    .i_imm    (in_imm),
    .i_data   (in_data),
    .i_boff   (in_boff),
    .o_result (w_core_data),
    .o_err    (w_core_err)
  );

  // in_ready comes straight from a flop, so out_ready never reaches it combinationally
  assign in_ready = ~r_skid_valid;
  assign w_accept = in_valid & ~r_skid_valid & ~flush;
  assign w_drain  = r_main_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_valid <= 1'b0;
      r_main_data  <= '0;
      r_main_err   <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_err   <= 1'b0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_drain) begin
      if (r_skid_valid) begin
        r_main_data  <= r_skid_data;
        r_main_err   <= r_skid_err;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_main_data  <= w_core_data;
        r_main_err   <= w_core_err;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_accept) begin
      // Main is empty or stalled here; a stalled main pushes the newcomer into the skid slot
      if (!r_main_valid) begin
        r_main_valid <= 1'b1;
        r_main_data  <= w_core_data;
        r_main_err   <= w_core_err;
      end else begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= w_core_data;
        r_skid_err   <= w_core_err;
      end
    end
  end

  assign out_valid = r_main_valid;
  assign out_data  = r_main_data;
  assign out_err   = r_main_err;

endmodule

`default_nettype wire
